// File: rtl/morse_encoder.sv
// Serial Morse encoder: one ASCII character in, two bits per symbol out.
// MORSE_DIGITS_EN adds digits 0-9.
module morse_encoder (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] entrada,
  input  logic       valido,
  output logic       pronto,
  output logic       saida,
  output logic       ativo,
  output logic       erro
);

  typedef enum logic [1:0] {IDLE, SYMBOL, TERM} state_t;

  state_t     state, state_n;
  logic [7:0] code, code_n;
  logic [2:0] cnt, cnt_n;
  logic       ph, ph_n;
  logic       np, np_n;
  logic       saida_n, ativo_n, erro_n;
  logic       acc;
  logic [7:0] up;
  logic [2:0] lk_len;
  logic [4:0] lk_code;

  // Codes are read MSB first; a 1 bit is a dash.
  always_comb begin
    up = entrada;
    if (entrada >= 8'h61 && entrada <= 8'h7A)
      up = entrada - 8'h20;
    lk_len  = 3'd0;
    lk_code = 5'b0;
    case (up)
      8'h41: {lk_len, lk_code} = {3'd2, 5'b00001};
      8'h42: {lk_len, lk_code} = {3'd4, 5'b01000};
      8'h43: {lk_len, lk_code} = {3'd4, 5'b01010};
      8'h44: {lk_len, lk_code} = {3'd3, 5'b00100};
      8'h45: {lk_len, lk_code} = {3'd1, 5'b00000};
      8'h46: {lk_len, lk_code} = {3'd4, 5'b00010};
      8'h47: {lk_len, lk_code} = {3'd3, 5'b00110};
      8'h48: {lk_len, lk_code} = {3'd4, 5'b00000};
      8'h49: {lk_len, lk_code} = {3'd2, 5'b00000};
      8'h4A: {lk_len, lk_code} = {3'd4, 5'b00111};
      8'h4B: {lk_len, lk_code} = {3'd3, 5'b00101};
      8'h4C: {lk_len, lk_code} = {3'd4, 5'b00100};
      8'h4D: {lk_len, lk_code} = {3'd2, 5'b00011};
      8'h4E: {lk_len, lk_code} = {3'd2, 5'b00010};
      8'h4F: {lk_len, lk_code} = {3'd3, 5'b00111};
      8'h50: {lk_len, lk_code} = {3'd4, 5'b00110};
      8'h51: {lk_len, lk_code} = {3'd4, 5'b01101};
      8'h52: {lk_len, lk_code} = {3'd3, 5'b00010};
      8'h53: {lk_len, lk_code} = {3'd3, 5'b00000};
      8'h54: {lk_len, lk_code} = {3'd1, 5'b00001};
      8'h55: {lk_len, lk_code} = {3'd3, 5'b00001};
      8'h56: {lk_len, lk_code} = {3'd4, 5'b00001};
      8'h57: {lk_len, lk_code} = {3'd3, 5'b00011};
      8'h58: {lk_len, lk_code} = {3'd4, 5'b01001};
      8'h59: {lk_len, lk_code} = {3'd4, 5'b01011};
      8'h5A: {lk_len, lk_code} = {3'd4, 5'b01100};
`ifdef MORSE_DIGITS_EN
      8'h30: {lk_len, lk_code} = {3'd5, 5'b11111};
      8'h31: {lk_len, lk_code} = {3'd5, 5'b01111};
      8'h32: {lk_len, lk_code} = {3'd5, 5'b00111};
      8'h33: {lk_len, lk_code} = {3'd5, 5'b00011};
      8'h34: {lk_len, lk_code} = {3'd5, 5'b00001};
      8'h35: {lk_len, lk_code} = {3'd5, 5'b00000};
      8'h36: {lk_len, lk_code} = {3'd5, 5'b10000};
      8'h37: {lk_len, lk_code} = {3'd5, 5'b11000};
      8'h38: {lk_len, lk_code} = {3'd5, 5'b11100};
      8'h39: {lk_len, lk_code} = {3'd5, 5'b11110};
`endif
      default: ;
    endcase
  end

  // Ready in idle and while the last bit of a character is on the line.
  assign pronto = (state == IDLE) || (state == TERM && ph);
  assign acc    = valido && pronto;

  always_comb begin
    state_n = state;
    code_n  = code;
    cnt_n   = cnt;
    ph_n    = ph;
    np_n    = np;
    erro_n  = 1'b0;
    if (acc) begin
      code_n = 8'h00;
      cnt_n  = 3'd0;
      ph_n   = 1'b0;
      np_n   = 1'b0;
      if (lk_len != 3'd0) begin
        state_n = SYMBOL;
        code_n  = {3'b000, lk_code};
        cnt_n   = lk_len - 3'd1;
      end else if (entrada == 8'h20) begin
        state_n = TERM;
        np_n    = 1'b1;
      end else begin
        state_n = IDLE;
        erro_n  = 1'b1;
      end
    end else begin
      case (state)
        SYMBOL: begin
          if (!ph) begin
            ph_n = 1'b1;
          end else if (cnt == 3'd0) begin
            state_n = TERM;
            ph_n    = 1'b0;
            np_n    = 1'b0;
          end else begin
            cnt_n = cnt - 3'd1;
            ph_n  = 1'b0;
          end
        end
        TERM: begin
          if (!ph) begin
            ph_n = 1'b1;
          end else begin
            state_n = IDLE;
            ph_n    = 1'b0;
            np_n    = 1'b0;
          end
        end
        default: ;
      endcase
    end
    saida_n = 1'b0;
    case (state_n)
      SYMBOL:  saida_n = ~code_n[cnt_n];
      TERM:    saida_n = np_n ? ph_n : ~ph_n;
      default: saida_n = 1'b0;
    endcase
    ativo_n = (state_n != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      code  <= 8'h00;
      cnt   <= 3'd0;
      ph    <= 1'b0;
      np    <= 1'b0;
      saida <= 1'b0;
      ativo <= 1'b0;
      erro  <= 1'b0;
    end else begin
      state <= state_n;
      code  <= code_n;
      cnt   <= cnt_n;
      ph    <= ph_n;
      np    <= np_n;
      saida <= saida_n;
      ativo <= ativo_n;
      erro  <= erro_n;
    end
  end

endmodule

// File: tb/tb_morse_encoder.sv
// Scoreboard bench for morse_encoder; honours MORSE_DIGITS_EN
// when the same macro is defined for the build.
module tb_morse_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] entrada = 8'h00;
  logic       valido = 1'b0;
  logic       pronto, saida, ativo, erro;

  int errs = 0;
  int checks = 0;
  bit exp_q[$];
  int exp_err = 0;

  morse_encoder dut (
    .clock(clk), .reset(rst), .entrada(entrada), .valido(valido),
    .pronto(pronto), .saida(saida), .ativo(ativo), .erro(erro)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic string morse(input logic [7:0] c);
    logic [7:0] u;
    u = c;
    if (c >= 8'h61 && c <= 8'h7A) u = c - 8'h20;
    case (u)
      "A": return ".-";    "B": return "-...";  "C": return "-.-.";
      "D": return "-..";   "E": return ".";     "F": return "..-.";
      "G": return "--.";   "H": return "....";  "I": return "..";
      "J": return ".---";  "K": return "-.-";   "L": return ".-..";
      "M": return "--";    "N": return "-.";    "O": return "---";
      "P": return ".--.";  "Q": return "--.-";  "R": return ".-.";
      "S": return "...";   "T": return "-";     "U": return "..-";
      "V": return "...-";  "W": return ".--";   "X": return "-..-";
      "Y": return "-.--";  "Z": return "--..";
`ifdef MORSE_DIGITS_EN
      "0": return "-----"; "1": return ".----"; "2": return "..---";
      "3": return "...--"; "4": return "....-"; "5": return ".....";
      "6": return "-...."; "7": return "--..."; "8": return "---..";
      "9": return "----.";
`endif
      default: return "";
    endcase
  endfunction

  task automatic push_exp(input logic [7:0] c);
    string s;
    if (c == 8'h20) begin
      exp_q.push_back(1'b0);
      exp_q.push_back(1'b1);
    end else begin
      s = morse(c);
      if (s.len() == 0) exp_err++;
      else begin
        for (int i = 0; i < s.len(); i++) begin
          exp_q.push_back(s[i] == "." ? 1'b1 : 1'b0);
          exp_q.push_back(s[i] == "." ? 1'b1 : 1'b0);
        end
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
      end
    end
  endtask

  task automatic send(input logic [7:0] c);
    int n;
    n = 0;
    @(negedge clk);
    while (!pronto && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!pronto) check("pronto_wait", pronto, 1);
    entrada = c;
    valido  = 1'b1;
    @(posedge clk);
    push_exp(c);
  endtask

  task automatic idle(input int cycles);
    @(negedge clk);
    valido  = 1'b0;
    entrada = 8'($urandom);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_err != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  // Per-cycle monitor: pronto/ativo follow the queue depth.
  always @(negedge clk) begin
    if (!rst) begin
      check("ativo", ativo, exp_q.size() != 0);
      check("pronto", pronto, exp_q.size() <= 1);
      check("erro", erro, exp_err > 0);
      if (exp_err > 0) exp_err--;
      if (ativo && exp_q.size() != 0) check("saida", saida, exp_q.pop_front());
      else if (!ativo) check("saida_idle", saida, 0);
    end
  end

  initial begin
    #2;
    check("rst_pronto", pronto, 1);
    check("rst_ativo", ativo, 0);
    check("rst_saida", saida, 0);
    check("rst_erro", erro, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    send("E"); idle(2);
    send("e"); idle(2);
    send("A"); send("M"); idle(2);
    send("I"); send(" "); send("H"); idle(2);
    send("#"); send("N"); idle(2);
    send("5"); idle(2);
    send("z"); send("{"); send("@"); send("Q"); idle(2);
    for (int i = 0; i < 8; i++)
      send(8'($urandom_range(0, 25)) + 8'h41);
    idle(1);
    drain();

    // Reset in the middle of 'O', then 'T' on the first edge after release.
    send("O");
    @(negedge clk);
    @(negedge clk);
    valido = 1'b0;
    @(posedge clk);
    #2;
    check("pre_rst_ativo", ativo, 1);
    rst = 1'b1;
    #1;
    check("arst_saida", saida, 0);
    check("arst_ativo", ativo, 0);
    check("arst_erro", erro, 0);
    check("arst_pronto", pronto, 1);
    exp_q.delete();
    exp_err = 0;
    entrada = "E";
    valido  = 1'b1;
    repeat (2) @(negedge clk);
    check("in_rst_ativo", ativo, 0);
    rst     = 1'b0;
    entrada = "T";
    @(posedge clk);
    push_exp("T");
    idle(2);
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
